// File: rtl/prio_enc_pkg.sv
// Shared constants and bit-vector helpers for the priority encoder family.
// Helpers work on a 64-bit container; callers size-cast in and out.
package prio_enc_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Returns 0 when no bit is set; callers pair it with a separate found flag.
    function automatic logic [5:0] msb_index(input logic [63:0] vec);
        logic [5:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (vec[i]) r = 6'(i);
        end
        return r;
    endfunction

    function automatic logic [63:0] onehot_of(input logic [5:0] idx);
        logic [63:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/prio_encoder_rr_if.sv
// Request/enable/mode in, registered index out with a valid/ready handshake.
// master = request source plus consumer, slave = the encoder.
interface prio_encoder_rr_if #(
    parameter int N = 8
);
    localparam int W = $clog2(N);

    logic         en;
    logic [N-1:0] req;
    logic         mode;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic [N-1:0] out_onehot;
    logic         out_multi;

    modport master (
        output en, req, mode, out_ready,
        input  out_valid, out_idx, out_onehot, out_multi
    );

    modport slave (
        input  en, req, mode, out_ready,
        output out_valid, out_idx, out_onehot, out_multi
    );

endinterface

// File: rtl/prio_msb_find.sv
// Highest set bit of (vec & mask); purely combinational, no latency.
// No handshake of its own; found is low when the masked vector is empty.
module prio_msb_find
    import prio_enc_pkg::*;
#(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic [N-1:0] mask,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [N-1:0] masked;

    always_comb begin
        masked = vec & mask;
        found  = |masked;
        idx    = W'(msb_index(64'(masked)));
    end

endmodule

// File: rtl/prio_encoder_rr.sv
// N-to-log2(N) fixed/round-robin priority encoder, one cycle capture-to-output.
// Outputs and ptr freeze while out_valid & !out_ready; new capture replaces a transfer with no bubble.
module prio_encoder_rr
    import prio_enc_pkg::*;
#(
    parameter int N = 8
) (
    input  logic               clk,
    input  logic               rst,
    prio_encoder_rr_if.slave   bus
);

    localparam int W = $clog2(N);

    logic [W-1:0] ptr_q,        ptr_d;
    logic         out_valid_q,  out_valid_d;
    logic [W-1:0] out_idx_q,    out_idx_d;
    logic [N-1:0] out_onehot_q, out_onehot_d;
    logic         out_multi_q,  out_multi_d;

    logic [N-1:0] prio_mask;
    logic         m_found, a_found;
    logic [W-1:0] m_idx, a_idx;
    logic [W-1:0] winner;
    logic         acc;

    // In round-robin mode only indices 0..ptr are eligible on the first pass.
    always_comb begin
        prio_mask = '1;
        if (bus.mode == MODE_RR) begin
            for (int i = 0; i < N; i++) begin
                prio_mask[i] = (W'(i) <= ptr_q);
            end
        end
    end

    prio_msb_find #(.N(N)) u_masked (
        .vec   (bus.req),
        .mask  (prio_mask),
        .found (m_found),
        .idx   (m_idx)
    );

    prio_msb_find #(.N(N)) u_any (
        .vec   (bus.req),
        .mask  ({N{1'b1}}),
        .found (a_found),
        .idx   (a_idx)
    );

    always_comb begin
        winner       = m_found ? m_idx : a_idx;
        acc          = bus.en & a_found & (~out_valid_q | bus.out_ready);

        ptr_d        = ptr_q;
        out_valid_d  = out_valid_q;
        out_idx_d    = out_idx_q;
        out_onehot_d = out_onehot_q;
        out_multi_d  = out_multi_q;

        if (acc) begin
            out_valid_d  = 1'b1;
            out_idx_d    = winner;
            out_onehot_d = N'(onehot_of(6'(winner)));
            out_multi_d  = |(bus.req & (bus.req - N'(1)));
            // N is a power of two, so winner-1 wraps 0 to N-1 naturally.
            if (bus.mode == MODE_RR) ptr_d = winner - W'(1);
        end else if (out_valid_q & bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= W'(N - 1);
            out_valid_q  <= 1'b0;
            out_idx_q    <= '0;
            out_onehot_q <= '0;
            out_multi_q  <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            out_valid_q  <= out_valid_d;
            out_idx_q    <= out_idx_d;
            out_onehot_q <= out_onehot_d;
            out_multi_q  <= out_multi_d;
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_idx    = out_idx_q;
    assign bus.out_onehot = out_onehot_q;
    assign bus.out_multi  = out_multi_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed-vector bench for prio_encoder_rr (N=8) plus a 4-input legacy instance.
module tb_prio_encoder_rr;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    prio_encoder_rr_if #(.N(8)) bus  ();
    prio_encoder_rr_if #(.N(4)) bus4 ();

    prio_encoder_rr #(.N(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
    prio_encoder_rr #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          rr_seq [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    int          rr2_seq[3] = '{2, 1, 2};
    logic [7:0]  bp_req [4] = '{8'hFF, 8'h00, 8'h0F, 8'h80};

    initial begin
        rst = 1'b1;
        bus.en = 1'b1;  bus.req = 8'hFF; bus.mode = 1'b0; bus.out_ready = 1'b1;
        bus4.en = 1'b1; bus4.req = 4'h0; bus4.mode = 1'b0; bus4.out_ready = 1'b1;

        tick(); tick();
        check("rst_valid",  bus.out_valid,  0);
        check("rst_idx",    bus.out_idx,    0);
        check("rst_onehot", bus.out_onehot, 0);
        check("rst_multi",  bus.out_multi,  0);
        check("rst_ptr",    dut.ptr_q,      7);

        rst = 1'b0;
        tick();
        check("first_valid", bus.out_valid, 1);
        check("first_idx",   bus.out_idx,   7);

        bus.req = 8'b0010_1100;
        tick();
        check("fix_valid",  bus.out_valid,  1);
        check("fix_idx",    bus.out_idx,    5);
        check("fix_onehot", bus.out_onehot, 8'h20);
        check("fix_multi",  bus.out_multi,  1);

        bus.req  = 8'h01;
        bus4.req = 4'b1111;
        tick();
        check("fix1_idx",    bus.out_idx,     0);
        check("fix1_multi",  bus.out_multi,   0);
        check("fix1_onehot", bus.out_onehot,  8'h01);
        check("n4_idx",      bus4.out_idx,    3);
        check("n4_onehot",   bus4.out_onehot, 4'h8);
        check("fix_ptr",     dut.ptr_q,       7);

        bus.mode = 1'b1;
        bus.req  = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            tick();
            check($sformatf("rr_idx%0d", i), bus.out_idx, rr_seq[i]);
        end
        check("rr_ptr", dut.ptr_q, 6);

        bus.req = 8'b0000_0110;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rr2_idx%0d", i), bus.out_idx, rr2_seq[i]);
        end
        check("rr2_ptr", dut.ptr_q, 1);

        bus.mode = 1'b0;
        bus.req  = 8'h20;
        tick();
        check("bp_load", bus.out_idx, 5);

        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.req  = bp_req[i];
            bus.mode = i[0];
            tick();
            check($sformatf("bp_valid%0d", i),  bus.out_valid,  1);
            check($sformatf("bp_idx%0d", i),    bus.out_idx,    5);
            check($sformatf("bp_onehot%0d", i), bus.out_onehot, 8'h20);
            check($sformatf("bp_ptr%0d", i),    dut.ptr_q,      1);
        end

        bus.out_ready = 1'b1;
        bus.mode      = 1'b0;
        bus.req       = 8'h08;
        tick();
        check("nobub_valid", bus.out_valid, 1);
        check("nobub_idx",   bus.out_idx,   3);

        bus.en  = 1'b0;
        bus.req = 8'hFF;
        tick();
        check("en0_valid", bus.out_valid, 0);
        check("en0_idx",   bus.out_idx,   3);

        bus.en = 1'b1;
        tick();
        check("en1_valid", bus.out_valid, 1);
        check("en1_idx",   bus.out_idx,   7);

        bus.req = 8'h00;
        tick();
        check("req0_valid", bus.out_valid, 0);
        check("req0_idx",   bus.out_idx,   7);
        check("req0_ptr",   dut.ptr_q,     1);

        bus.mode = 1'b1;
        bus.req  = 8'h10;
        tick();
        check("wrap_idx", bus.out_idx, 4);
        check("wrap_ptr", dut.ptr_q,   3);

        bus.out_ready = 1'b0;
        rst           = 1'b1;
        tick();
        check("mrst_valid", bus.out_valid, 0);
        check("mrst_idx",   bus.out_idx,   0);
        check("mrst_ptr",   dut.ptr_q,     7);

        rst           = 1'b0;
        bus.out_ready = 1'b1;
        bus.req       = 8'hFF;
        tick();
        check("post_valid", bus.out_valid, 1);
        check("post_idx",   bus.out_idx,   7);
        check("post_ptr",   dut.ptr_q,     6);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/prio_encoder_rr.md
Name: prio_encoder_rr

Overview:
- Parametrised N-to-log2(N) encoder; generalises the team's fixed 4-to-2 encoder.
- Adds fixed-priority / round-robin mode, registered output and a valid/ready output handshake.
- Sits between request sources (interrupt lines, arbiter requests) and a consumer that accepts one encoded index per transfer.
- Throughput 1 index/cycle; latency 1 cycle.

Parameters:
- N, 8, number of request lines; legal values are 2 to 64 and powers of two.
- W, $clog2(N), index width. Derived localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- en  in  1  encode enable; when low, no new capture
- req  in  N  request lines; bit i = input i
- mode  in  1  0 = fixed priority (highest index wins), 1 = round-robin
- out_ready  in  1  consumer ready
- out_valid  out  1  registered index valid
- out_idx  out  W  encoded winning index
- out_onehot  out  N  one-hot of the winner
- out_multi  out  1  more than one req bit was set at capture

Behaviour:
- Reset: one clk edge with rst=1 sets:
  - out_valid=0, out_idx=0, out_onehot=0, out_multi=0
  - round-robin pointer ptr=N-1
  - rst overrides all other inputs, including mid-transfer; a pending output is discarded.
- Accept condition: acc = en & (|req) & (!out_valid | out_ready).
- On acc, the next edge loads the winner into out_idx/out_onehot/out_multi and sets out_valid=1. req is sampled only on the accept cycle and is not held internally.
- Fixed mode (mode=0): winner = highest set index. Legacy compatible: with N=4, i3 dominates i2 dominates i1 dominates i0. ptr is not modified.
- Round-robin mode (mode=1):
  - Winner = highest set index <= ptr. If none, winner = highest set index overall (wrap).
  - On accept with winner k: ptr <= (k-1) mod N, so k becomes lowest priority. k=0 gives ptr=N-1.
- Handshake:
  - Transfer occurs when out_valid & out_ready.
  - Transfer with no acc: out_valid <= 0; out_idx/out_onehot/out_multi hold their last values.
  - Transfer and acc in the same cycle: new result replaces the old one with no bubble.
  - out_valid & !out_ready: all outputs and ptr are frozen regardless of req, en or mode.
- req=0 or en=0: no capture and no ptr change. out_idx keeps its value (it is not forced to 0); consumers qualify it with out_valid.
- Mode change: takes effect at the next accept. ptr is retained across mode switches.
- out_multi = 1 iff popcount(req) >= 2 at capture.
- No combinational path from req, en or mode to any output. out_ready feeds only the internal accept logic.

Decomposition:
- Package prio_enc_pkg holds:
  - MODE_FIXED=1'b0 and MODE_RR=1'b1
  - function msb_index(vector), returning the highest set index
  - function onehot_of(index)
- Sub-module prio_msb_find (combinational) with parameter N, inputs vec[N-1:0] and mask[N-1:0], outputs found and idx[W-1:0].
- Top-level use:
  - Instance 1: mask=all-ones in fixed mode; in RR mode, mask = bits 0..ptr.
  - Instance 2: unmasked, used for the RR wrap case.
- Top level holds the output register, ptr register and handshake logic.

Test Plan:
- Reset: hold rst 2 cycles with req=8'hFF, en=1 -> out_valid=0, out_idx=0, out_onehot=0, ptr=7. Release -> first result appears one cycle later.
- Fixed mode: N=8, req=8'b0010_1100, en=1, out_ready=1 -> next cycle out_valid=1, out_idx=5, out_onehot=8'h20, out_multi=1. Then req=8'h01 -> out_idx=0, out_multi=0.
- Round-robin: mode=1, req=8'hFF held, out_ready=1 for 9 cycles -> out_idx sequence 7,6,5,4,3,2,1,0,7. Then req=8'b0000_0110 with ptr=6 -> 2, then 1, then 2.
- Backpressure: out_valid=1, idx=5, out_ready=0 for 4 cycles while req toggles -> outputs and ptr frozen. Raise out_ready with req=8'h08 -> next cycle idx=3, with no bubble.
- Idle/enable: en=0 with req=8'hFF, or en=1 with req=0, during a transfer -> out_valid falls to 0 and out_idx holds. N=4, req=4'b1111, mode=0 -> idx=3 (legacy equivalence).
- Mid-operation reset: RR mode with ptr=3 and out_valid=1, out_ready=0; assert rst 1 cycle -> out_valid=0, ptr=7. Next accept of req=8'hFF -> idx=7.
